commit_writeback: RTL and testbench
===================================

Name: commit_writeback

Overview:
- Final stage of the dual-issue pipeline. Consumes the registered two-lane commit bundle (instr, rd, pc, write data, regwrite per lane) and writes it into the architectural integer register file.
- Exposes 4 read ports to the decode/issue stage.
- Maintains a 64-bit retired-instruction counter and the PC of the youngest retired instruction.
- Lane 1 is program-order older; lane 2 is younger.

Parameters:
- XLEN, 32, data/PC width
- NREG, 32, architectural registers (address width = clog2(NREG) = 5)
- CNT_W, 64, retire counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cm_instr1  in  32  lane-1 instruction word; 32'h0 = bubble
- cm_instr2  in  32  lane-2 instruction word; 32'h0 = bubble
- cm_rd1  in  5  lane-1 destination
- cm_rd2  in  5  lane-2 destination
- cm_pc1  in  XLEN  lane-1 PC
- cm_pc2  in  XLEN  lane-2 PC
- cm_wdata1  in  XLEN  lane-1 result
- cm_wdata2  in  XLEN  lane-2 result
- cm_we1  in  1  lane-1 regwrite
- cm_we2  in  1  lane-2 regwrite
- rs_addr0..rs_addr3  in  5 each  read addresses
- rs_data0..rs_data3  out  XLEN each  read data (combinational)
- retire_cnt  out  CNT_W  instructions retired since reset
- last_pc  out  XLEN  PC of youngest retired instruction
- retire_num  out  2  instructions retired this cycle (0..2), registered

Behaviour:
- Reset (rstn low, async): all NREG registers = 0, retire_cnt = 0, last_pc = 0, retire_num = 0. Reset may assert mid-stream; state clears immediately and the in-flight bundle is dropped.
- Register write, 1-cycle latency: a lane with cm_weN=1 and cm_rdN!=0 writes cm_wdataN at the clock edge.
- Write conflict: if both lanes write the same rd, lane 2's data lands (program order).
- x0: writes to x0 are ignored; reads of x0 always return 0.
- Regwrite on a bubble: cm_weN=1 with cm_instrN==0 still performs the write. The bubble test affects counting only.
- Reads without BYPASS_EN: rs_dataK = stored value only; a same-cycle write becomes visible the following cycle.
- Retire valid: lane N is valid when cm_instrN != 0. valid = {v2, v1} gives popcount 0..2.
- retire_cnt: adds popcount each cycle and wraps modulo 2^CNT_W.
- retire_num: registered popcount of the current cycle's bundle.
- last_pc: takes cm_pc2 if v2, else cm_pc1 if v1, else holds its value.
- Lane-2-only valid (v1=0, v2=1): legal; counts 1 and last_pc = cm_pc2.
- No backpressure: the stage accepts a bundle every cycle.

Optional Feature:
- Macro: COMMIT_WB_BYPASS_EN.
- When defined: each read port forwards same-cycle commit data when rs_addrK matches a writing lane's rd (rd != 0). Lane 2 has priority over lane 1, and lane 1 over the stored value. Read-to-data is combinational, giving 0-cycle write-to-read visibility.
- When undefined: no forwarding. Upstream hazard logic must cover the 1-cycle window.
- x0 returns 0 in both builds.

Decomposition:
- Package commit_pkg holds:
  - XLEN, NREG, CNT_W, REG_AW (=5)
  - BUBBLE_INSTR = 32'h0
  - typedef commit_lane_t {instr, rd, pc, wdata, we}
- One sub-module, regfile_2w4r: the storage array with 2 write ports (lane-2 priority), 4 combinational read ports, x0 masking and async reset.
- commit_writeback wraps regfile_2w4r and adds the counter, last_pc, retire_num and the optional bypass muxes.

Test Plan:
- Reset then single write: release rstn; commit lane1 instr=32'h00500093, rd=1, wdata=5, we=1 → next cycle rs_data0 (addr 1) = 5, retire_cnt = 1, retire_num = 1, last_pc = cm_pc1.
- Same-rd conflict: both lanes we=1, rd=7, wdata1=0xAAAA, wdata2=0x5555 → x7 = 0x5555, retire_cnt += 2, last_pc = cm_pc2.
- x0 protection: lane1 rd=0, wdata=0xFFFF_FFFF, we=1 → rs_data(addr 0) = 0; counter still +1.
- Bubbles: instr1 = instr2 = 0 for 10 cycles → retire_cnt unchanged, retire_num = 0, last_pc held.
- Bypass build: lane2 rd=3, wdata=0x1234, we=1 with rs_addr2=3 in the same cycle → rs_data2 = 0x1234 with COMMIT_WB_BYPASS_EN, old x3 without.
- Mid-stream reset: after 100 retirements and x5=0x99, pulse rstn low between edges → retire_cnt = 0, x5 = 0 immediately; wrap test preloads the counter to 2^64-1 via force, then commits 2 → retire_cnt = 1.

Source files
------------

// File: rtl/commit_pkg.sv
// rtl/commit_pkg.sv - shared widths, bubble encoding and commit lane record for the writeback stage
package commit_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int CNT_W  = 64;
    localparam int REG_AW = 5;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    // One lane of the registered commit bundle; field order fixes the packed layout.
    typedef struct packed {
        logic [31:0]       instr;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   wdata;
        logic              we;
    } commit_lane_t;

endpackage

// File: rtl/regfile_2w4r.sv
// rtl/regfile_2w4r.sv - integer register file, two write ports with lane-2 priority, four combinational reads
module regfile_2w4r
    import commit_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              we1_i,
    input  logic [REG_AW-1:0] waddr1_i,
    input  logic [XLEN-1:0]   wdata1_i,
    input  logic              we2_i,
    input  logic [REG_AW-1:0] waddr2_i,
    input  logic [XLEN-1:0]   wdata2_i,
    input  logic [REG_AW-1:0] raddr0_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    input  logic [REG_AW-1:0] raddr3_i,
    output logic [XLEN-1:0]   rdata0_o,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o,
    output logic [XLEN-1:0]   rdata3_o
);

    logic [XLEN-1:0] regs_q [NREG];

    // Storage update: lane 2 is written last so it wins a same-rd conflict; x0 is never written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we1_i && (waddr1_i != '0)) begin
                regs_q[waddr1_i] <= wdata1_i;
            end
            if (we2_i && (waddr2_i != '0)) begin
                regs_q[waddr2_i] <= wdata2_i;
            end
        end
    end

    // Read ports: x0 is masked to zero regardless of array contents.
    always_comb begin
        rdata0_o = (raddr0_i == '0) ? '0 : regs_q[raddr0_i];
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
        rdata3_o = (raddr3_i == '0) ? '0 : regs_q[raddr3_i];
    end

endmodule

// File: rtl/commit_writeback.sv
// rtl/commit_writeback.sv - dual-lane commit writeback with retire counting; COMMIT_WB_BYPASS_EN adds same-cycle read forwarding
module commit_writeback
    import commit_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       cm_instr1,
    input  logic [31:0]       cm_instr2,
    input  logic [REG_AW-1:0] cm_rd1,
    input  logic [REG_AW-1:0] cm_rd2,
    input  logic [XLEN-1:0]   cm_pc1,
    input  logic [XLEN-1:0]   cm_pc2,
    input  logic [XLEN-1:0]   cm_wdata1,
    input  logic [XLEN-1:0]   cm_wdata2,
    input  logic              cm_we1,
    input  logic              cm_we2,
    input  logic [REG_AW-1:0] rs_addr0,
    input  logic [REG_AW-1:0] rs_addr1,
    input  logic [REG_AW-1:0] rs_addr2,
    input  logic [REG_AW-1:0] rs_addr3,
    output logic [XLEN-1:0]   rs_data0,
    output logic [XLEN-1:0]   rs_data1,
    output logic [XLEN-1:0]   rs_data2,
    output logic [XLEN-1:0]   rs_data3,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [XLEN-1:0]   last_pc,
    output logic [1:0]        retire_num
);

    commit_lane_t lane1, lane2;
    logic         v1, v2;
    logic [1:0]   retire_pop;

    logic [CNT_W-1:0] retire_cnt_q;
    logic [XLEN-1:0]  last_pc_q;
    logic [1:0]       retire_num_q;

    logic [XLEN-1:0] stored0, stored1, stored2, stored3;

    assign lane1 = {cm_instr1, cm_rd1, cm_pc1, cm_wdata1, cm_we1};
    assign lane2 = {cm_instr2, cm_rd2, cm_pc2, cm_wdata2, cm_we2};

    // A lane retires when it carries a real instruction; the regwrite flag plays no part here.
    assign v1         = (lane1.instr != BUBBLE_INSTR);
    assign v2         = (lane2.instr != BUBBLE_INSTR);
    assign retire_pop = {1'b0, v1} + {1'b0, v2};

    regfile_2w4r u_regfile (
        .clk      (clk),
        .rstn     (rstn),
        .we1_i    (lane1.we),
        .waddr1_i (lane1.rd),
        .wdata1_i (lane1.wdata),
        .we2_i    (lane2.we),
        .waddr2_i (lane2.rd),
        .wdata2_i (lane2.wdata),
        .raddr0_i (rs_addr0),
        .raddr1_i (rs_addr1),
        .raddr2_i (rs_addr2),
        .raddr3_i (rs_addr3),
        .rdata0_o (stored0),
        .rdata1_o (stored1),
        .rdata2_o (stored2),
        .rdata3_o (stored3)
    );

    // Retire bookkeeping: wrapping counter, youngest retired PC, and this bundle's retire count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            retire_cnt_q <= '0;
            last_pc_q    <= '0;
            retire_num_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(retire_pop);
            retire_num_q <= retire_pop;
            if (v2) begin
                last_pc_q <= lane2.pc;
            end else if (v1) begin
                last_pc_q <= lane1.pc;
            end
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign last_pc    = last_pc_q;
    assign retire_num = retire_num_q;

`ifdef COMMIT_WB_BYPASS_EN
    // Forward the in-flight commit: lane 2 over lane 1 over storage; x0 stays zero.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   stored,
        input commit_lane_t      l1,
        input commit_lane_t      l2
    );
        if (addr == '0) begin
            return '0;
        end else if (l2.we && (l2.rd == addr)) begin
            return l2.wdata;
        end else if (l1.we && (l1.rd == addr)) begin
            return l1.wdata;
        end
        return stored;
    endfunction

    // Read data with same-cycle forwarding from the commit bundle.
    always_comb begin
        rs_data0 = fwd_sel(rs_addr0, stored0, lane1, lane2);
        rs_data1 = fwd_sel(rs_addr1, stored1, lane1, lane2);
        rs_data2 = fwd_sel(rs_addr2, stored2, lane1, lane2);
        rs_data3 = fwd_sel(rs_addr3, stored3, lane1, lane2);
    end
`else
    // Read data straight from storage; a write becomes visible the cycle after it commits.
    always_comb begin
        rs_data0 = stored0;
        rs_data1 = stored1;
        rs_data2 = stored2;
        rs_data3 = stored3;
    end
`endif

endmodule

// File: tb/tb_commit_writeback.sv
// tb/tb_commit_writeback.sv - directed scoreboard bench for commit_writeback
module tb_commit_writeback;

    logic        clk;
    logic        rstn;
    logic [31:0] cm_instr1, cm_instr2;
    logic [4:0]  cm_rd1, cm_rd2;
    logic [31:0] cm_pc1, cm_pc2, cm_wdata1, cm_wdata2;
    logic        cm_we1, cm_we2;
    logic [4:0]  rs_addr0, rs_addr1, rs_addr2, rs_addr3;
    logic [31:0] rs_data0, rs_data1, rs_data2, rs_data3;
    logic [63:0] retire_cnt;
    logic [31:0] last_pc;
    logic [1:0]  retire_num;

    commit_writeback dut (
        .clk(clk), .rstn(rstn),
        .cm_instr1(cm_instr1), .cm_instr2(cm_instr2),
        .cm_rd1(cm_rd1), .cm_rd2(cm_rd2),
        .cm_pc1(cm_pc1), .cm_pc2(cm_pc2),
        .cm_wdata1(cm_wdata1), .cm_wdata2(cm_wdata2),
        .cm_we1(cm_we1), .cm_we2(cm_we2),
        .rs_addr0(rs_addr0), .rs_addr1(rs_addr1), .rs_addr2(rs_addr2), .rs_addr3(rs_addr3),
        .rs_data0(rs_data0), .rs_data1(rs_data1), .rs_data2(rs_data2), .rs_data3(rs_data3),
        .retire_cnt(retire_cnt), .last_pc(last_pc), .retire_num(retire_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0..3 read port k at addr, 4 retire_cnt, 5 last_pc, 6 retire_num
    typedef struct {
        int          sel;
        logic [4:0]  addr;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mreg [32];
    logic [63:0] mcnt;
    logic [31:0] mpc;
    logic [1:0]  mnum;

    function automatic string sel_name(input int s);
        case (s)
            0: return "rs_data0";
            1: return "rs_data1";
            2: return "rs_data2";
            3: return "rs_data3";
            4: return "retire_cnt";
            5: return "last_pc";
            default: return "retire_num";
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mcnt = '0;
        mpc  = '0;
        mnum = '0;
    endtask

    task automatic idle_inputs();
        cm_instr1 = '0; cm_instr2 = '0; cm_rd1 = '0; cm_rd2 = '0;
        cm_pc1 = '0; cm_pc2 = '0; cm_wdata1 = '0; cm_wdata2 = '0;
        cm_we1 = 1'b0; cm_we2 = 1'b0;
    endtask

    task automatic push_state();
        sb.push_back('{4, 5'd0, mcnt});
        sb.push_back('{5, 5'd0, {32'h0, mpc}});
        sb.push_back('{6, 5'd0, {62'h0, mnum}});
    endtask

    task automatic push_reg(input int port, input logic [4:0] a);
        sb.push_back('{port, a, {32'h0, mreg[a]}});
    endtask

    // Drive one bundle and push the post-edge expectations from the model.
    task automatic drive(input logic [31:0] i1, input logic [4:0] rd1, input logic [31:0] pc1,
                         input logic [31:0] wd1, input logic we1,
                         input logic [31:0] i2, input logic [4:0] rd2, input logic [31:0] pc2,
                         input logic [31:0] wd2, input logic we2);
        logic v1, v2;
        cm_instr1 = i1; cm_rd1 = rd1; cm_pc1 = pc1; cm_wdata1 = wd1; cm_we1 = we1;
        cm_instr2 = i2; cm_rd2 = rd2; cm_pc2 = pc2; cm_wdata2 = wd2; cm_we2 = we2;
        v1 = (i1 != 32'h0);
        v2 = (i2 != 32'h0);
        if (we1 && rd1 != 5'd0) mreg[rd1] = wd1;
        if (we2 && rd2 != 5'd0) mreg[rd2] = wd2;
        mnum = {1'b0, v1} + {1'b0, v2};
        mcnt = mcnt + 64'(mnum);
        if (v2) mpc = pc2;
        else if (v1) mpc = pc1;
        push_state();
    endtask

    // Clock the bundle in, return to idle, then pop and compare every expectation.
    task automatic step();
        exp_t e;
        logic [63:0] obs;
        @(posedge clk);
        #1;
        idle_inputs();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: begin rs_addr0 = e.addr; #1; obs = {32'h0, rs_data0}; end
                1: begin rs_addr1 = e.addr; #1; obs = {32'h0, rs_data1}; end
                2: begin rs_addr2 = e.addr; #1; obs = {32'h0, rs_data2}; end
                3: begin rs_addr3 = e.addr; #1; obs = {32'h0, rs_data3}; end
                4: obs = retire_cnt;
                5: obs = {32'h0, last_pc};
                default: obs = {62'h0, retire_num};
            endcase
            chk(sel_name(e.sel), obs, e.val);
        end
    endtask

    initial begin
        logic [31:0] old_x3;
        rstn = 1'b0;
        idle_inputs();
        rs_addr0 = 5'd1; rs_addr1 = 5'd7; rs_addr2 = 5'd0; rs_addr3 = 5'd5;
        model_reset();
        #12;
        // reset state
        chk("reset_cnt", retire_cnt, 64'h0);
        chk("reset_pc", {32'h0, last_pc}, 64'h0);
        chk("reset_num", {62'h0, retire_num}, 64'h0);
        chk("reset_x1", {32'h0, rs_data0}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // single write on lane 1
        drive(32'h00500093, 5'd1, 32'h1000, 32'd5, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        push_reg(0, 5'd1);
        step();

        // same-rd conflict: lane 2 wins
        drive(32'h00a00393, 5'd7, 32'h1004, 32'hAAAA, 1'b1, 32'h00b00393, 5'd7, 32'h1008, 32'h5555, 1'b1);
        push_reg(1, 5'd7);
        step();

        // x0 protection, counter still advances
        drive(32'hfff00013, 5'd0, 32'h100c, 32'hFFFF_FFFF, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        push_reg(2, 5'd0);
        step();

        // lane-2-only valid
        drive(32'h0, 5'd0, 32'h2000, 32'h0, 1'b0, 32'h00100113, 5'd2, 32'h2004, 32'hCAFE, 1'b1);
        push_reg(3, 5'd2);
        step();

        // regwrite on a bubble still writes, counts nothing
        drive(32'h0, 5'd9, 32'h3000, 32'h0BAD_F00D, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        push_reg(0, 5'd9);
        step();

        // ten bubble cycles: counter and last_pc hold
        for (int c = 0; c < 10; c++) begin
            drive(32'h0, 5'd0, 32'h4000 + c, 32'h0, 1'b0, 32'h0, 5'd0, 32'h5000 + c, 32'h0, 1'b0);
            step();
        end

        // same-cycle read of a register being written by lane 2
        drive(32'h00300193, 5'd3, 32'h6000, 32'h0000_0777, 1'b1, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
        step();
        old_x3 = mreg[3];
        cm_instr2 = 32'h00400193; cm_rd2 = 5'd3; cm_pc2 = 32'h6004; cm_wdata2 = 32'h1234; cm_we2 = 1'b1;
        cm_instr1 = 32'h00500193; cm_rd1 = 5'd3; cm_pc1 = 32'h6008; cm_wdata1 = 32'h4321; cm_we1 = 1'b1;
        rs_addr2 = 5'd3;
        #1;
`ifdef COMMIT_WB_BYPASS_EN
        chk("bypass_x3", {32'h0, rs_data2}, 64'h1234);
`else
        chk("bypass_x3", {32'h0, rs_data2}, {32'h0, old_x3});
`endif
        drive(32'h00500193, 5'd3, 32'h6008, 32'h4321, 1'b1, 32'h00400193, 5'd3, 32'h6004, 32'h1234, 1'b1);
        push_reg(2, 5'd3);
        step();

        // build up to 100 retirements with x5 = 0x99
        drive(32'h09900293, 5'd5, 32'h7000, 32'h99, 1'b1, 32'h00000013, 5'd0, 32'h7004, 32'h0, 1'b0);
        step();
        while (mcnt < 64'd100) begin
            drive(32'h00000013, 5'd0, 32'h7100, 32'h0, 1'b0, 32'h00000013, 5'd0, 32'h7104, 32'h0, 1'b0);
            step();
        end
        rs_addr3 = 5'd5;
        #1;
        chk("pre_reset_x5", {32'h0, rs_data3}, 64'h99);
        chk("pre_reset_cnt", retire_cnt, 64'd100);

        // mid-stream reset between edges drops the in-flight bundle
        cm_instr1 = 32'h00000013; cm_we1 = 1'b1; cm_rd1 = 5'd5; cm_wdata1 = 32'hDEAD;
        #1;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_cnt", retire_cnt, 64'h0);
        chk("midrst_x5", {32'h0, rs_data3}, 64'h0);
        chk("midrst_pc", {32'h0, last_pc}, 64'h0);
        @(posedge clk);
        #1;
        chk("midrst_hold_x5", {32'h0, rs_data3}, 64'h0);
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // counter wrap
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        mcnt = 64'hFFFF_FFFF_FFFF_FFFF;
        drive(32'h00000013, 5'd0, 32'h8000, 32'h0, 1'b0, 32'h00000013, 5'd0, 32'h8004, 32'h0, 1'b0);
        step();
        chk("wrap_cnt", retire_cnt, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
